// File: rtl/lms_training_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : lms_training_source_if
//  Description : Control/data bundle between a controller (master) and the
//                LMS training-stimulus generator (slave).
//                  start      - one-cycle run request
//                  train_len  - number of samples to emit
//                  amp        - PN symbol magnitude (positive)
//                  h0, h1     - plant taps, signed Q1.(W1-1)
//                  x_out      - reference sample (to LMS x_in)
//                  d_out      - plant response (to LMS d_in)
//                  valid      - x_out/d_out carry a new sample
//                  busy       - generator not idle
//                  done       - one-cycle end-of-run pulse
//  Revision    : 1.0  initial release
// ============================================================================
interface lms_training_source_if #(
  parameter int W1 = 16,
  parameter int CW = 16
);
  logic          start;
  logic [CW-1:0] train_len;
  logic [W1-1:0] amp;
  logic [W1-1:0] h0;
  logic [W1-1:0] h1;
  logic [W1-1:0] x_out;
  logic [W1-1:0] d_out;
  logic          valid;
  logic          busy;
  logic          done;

  modport master (
    output start, train_len, amp, h0, h1,
    input  x_out, d_out, valid, busy, done
  );

  modport slave (
    input  start, train_len, amp, h0, h1,
    output x_out, d_out, valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/lms_training_source.sv
`default_nettype none
// ============================================================================
//  Module      : lms_training_source
//  Description : PN training-stimulus generator for an LMS adaptive FIR.
//                Emits a +/-amp PN reference x[n] and the response
//                d[n] = sat((h0*s[n] + h1*s[n-1]) >>> (W1-1)) of a 2-tap
//                plant, one aligned sample per clock, for train_len samples.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - slave side of lms_training_source_if
//                         (start/train_len/amp/h0/h1 in,
//                          x_out/d_out/valid/busy/done out)
//  Revision    : 1.0  initial release
// ============================================================================
module lms_training_source #(
  parameter int          W1        = 16,
  parameter int          CW        = 16,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  wire                    clk,
  input  wire                    rst_n,
  lms_training_source_if.slave   bus
);

  localparam int PW = 2 * W1;      // full product width
  localparam int SW = 2 * W1 + 1;  // sum width (one guard bit)

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // x^16+x^14+x^13+x^11+1 Fibonacci step: feedback from taps 0,2,3,5.
  function automatic logic [15:0] f_lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [W1-1:0] f_sym(input logic neg, input logic [W1-1:0] a);
    return neg ? -a : a;
  endfunction

  // Full-width signed product via explicit sign extension; the low PW bits
  // of the extended multiply are the exact two's complement result.
  function automatic logic [PW-1:0] f_smul(input logic [W1-1:0] a, input logic [W1-1:0] b);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = {{W1{a[W1-1]}}, a};
    eb = {{W1{b[W1-1]}}, b};
    return ea * eb;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e         state_q,  state_d;
  logic           drain_q,  drain_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [CW-1:0]  len_q,    len_d;
  logic [W1-1:0]  amp_q,    amp_d;
  logic [W1-1:0]  h0_q,     h0_d;
  logic [W1-1:0]  h1_q,     h1_d;
  logic [15:0]    lfsr_q,   lfsr_d;

  // Stage 1: symbol register and symbol delay line
  logic [W1-1:0]  sym_q,    sym_d;
  logic [W1-1:0]  prev_q,   prev_d;
  // Stage 2: product registers and aligned x
  logic [PW-1:0]  p0_q,     p0_d;
  logic [PW-1:0]  p1_q,     p1_d;
  logic [W1-1:0]  xp_q,     xp_d;
  logic           pv_q,     pv_d;
  // Stage 3: outputs
  logic [W1-1:0]  x_q,      x_d;
  logic [W1-1:0]  d_q,      d_d;
  logic           v_q,      v_d;

  logic           w_accept;
  logic           w_run;
  logic           w_last_sym;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_shift;
  logic           w_ovf_hi;
  logic           w_ovf_lo;
  logic [W1-1:0]  w_sat;

  assign w_accept   = (state_q == S_IDLE) && bus.start;
  assign w_run      = (state_q == S_RUN);
  assign w_last_sym = (cnt_q == (len_q - CW'(1)));

  // --------------------------------------------------------------------------
  // Sum, arithmetic shift (floor) and saturation
  // --------------------------------------------------------------------------
  assign w_sum   = $signed({p0_q[PW-1], p0_q}) + $signed({p1_q[PW-1], p1_q});
  assign w_shift = w_sum >>> (W1 - 1);

  // Value fits in W1 bits only if every bit above the W1-bit sign matches it.
  assign w_ovf_hi = !w_shift[SW-1] &&  (|w_shift[SW-2:W1-1]);
  assign w_ovf_lo =  w_shift[SW-1] && !(&w_shift[SW-2:W1-1]);

  always_comb begin
    w_sat = w_shift[W1-1:0];
    if (w_ovf_hi) begin
      w_sat = {1'b0, {(W1-1){1'b1}}};
    end else if (w_ovf_lo) begin
      w_sat = {1'b1, {(W1-1){1'b0}}};
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.train_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_sym) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Two flush cycles: drain_q is 0 in the first, 1 in the second.
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    amp_d  = amp_q;
    h0_d   = h0_q;
    h1_d   = h1_q;
    lfsr_d = lfsr_q;
    sym_d  = sym_q;
    prev_d = prev_q;
    p0_d   = p0_q;
    p1_d   = p1_q;
    xp_d   = xp_q;
    pv_d   = w_run;
    x_d    = x_q;
    d_d    = d_q;
    v_d    = pv_q;

    if (w_accept) begin
      len_d  = bus.train_len;
      amp_d  = bus.amp;
      h0_d   = bus.h0;
      h1_d   = bus.h1;
      cnt_d  = '0;
      prev_d = '0;
      // The first symbol is taken from the seed right at accept so the symbol
      // register already holds s[0] in the first RUN cycle; the LFSR is
      // advanced past it so each RUN cycle then fetches the following symbol.
      sym_d  = f_sym(LFSR_INIT[0], bus.amp);
      lfsr_d = f_lfsr_step(LFSR_INIT);
    end else if (w_run) begin
      p0_d   = f_smul(h0_q, sym_q);
      p1_d   = f_smul(h1_q, prev_q);
      xp_d   = sym_q;
      prev_d = sym_q;
      sym_d  = f_sym(lfsr_q[0], amp_q);
      lfsr_d = f_lfsr_step(lfsr_q);
      cnt_d  = cnt_q + CW'(1);
    end

    // Outputs hold their last values whenever no new sample arrives.
    if (pv_q) begin
      x_d = xp_q;
      d_d = w_sat;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drain_q <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      amp_q   <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      lfsr_q  <= LFSR_INIT;
      sym_q   <= '0;
      prev_q  <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      xp_q    <= '0;
      pv_q    <= 1'b0;
      x_q     <= '0;
      d_q     <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      amp_q   <= amp_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      lfsr_q  <= lfsr_d;
      sym_q   <= sym_d;
      prev_q  <= prev_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      xp_q    <= xp_d;
      pv_q    <= pv_d;
      x_q     <= x_d;
      d_q     <= d_d;
      v_q     <= v_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.x_out = x_q;
  assign bus.d_out = d_q;
  assign bus.valid = v_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lms_training_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lms_training_source
//  Description : Self-checking bench for lms_training_source. A sample-level
//                model (plain integer arithmetic) predicts x/d sequences and
//                the busy/valid/done schedule relative to the accept edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lms_training_source;

  localparam int W1 = 16;
  localparam int CW = 16;

  logic clk;
  logic rst_n;

  lms_training_source_if #(.W1(W1), .CW(CW)) bus_if ();

  lms_training_source #(.W1(W1), .CW(CW), .LFSR_INIT(16'hACE1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_x [0:1023];
  logic [15:0] exp_d [0:1023];

  int          mon_en = 0;
  int          mon_k  = 0;
  int          mon_l  = 0;
  int          vcount = 0;
  logic [15:0] last_x = 16'h0;
  logic [15:0] last_d = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Sample-level model: PN symbols from the LFSR rule, plant output with
  // floor division by 2^15 and clamping to the 16-bit signed range.
  task automatic build_model(input int len, input logic [15:0] a,
                             input logic [15:0] h0v, input logic [15:0] h1v);
    logic [15:0] lf;
    longint      s;
    longint      prev;
    longint      acc;
    longint      q;
    lf   = 16'hACE1;
    prev = 0;
    for (int n = 0; n < len; n++) begin
      s    = lf[0] ? -longint'(a) : longint'(a);
      lf   = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
      acc  = longint'($signed(h0v)) * s + longint'($signed(h1v)) * prev;
      q    = acc >>> 15;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      exp_x[n] = s[15:0];
      exp_d[n] = q[15:0];
      prev = s;
    end
  endtask

  // Cycle-by-cycle compare relative to the accept edge (k = 1 is cycle T+1).
  always @(negedge clk) begin
    if (mon_en != 0) begin
      logic e_busy;
      logic e_done;
      logic e_valid;
      mon_k++;
      if (mon_l == 0) begin
        e_busy  = (mon_k == 1);
        e_done  = (mon_k == 1);
        e_valid = 1'b0;
      end else begin
        e_busy  = (mon_k >= 1) && (mon_k <= mon_l + 3);
        e_done  = (mon_k == mon_l + 3);
        e_valid = (mon_k >= 3) && (mon_k <= mon_l + 2);
      end
      chk("busy",  32'(bus_if.busy),  32'(e_busy));
      chk("done",  32'(bus_if.done),  32'(e_done));
      chk("valid", 32'(bus_if.valid), 32'(e_valid));
      if (bus_if.valid) vcount++;
      if (e_valid) begin
        last_x = exp_x[mon_k - 3];
        last_d = exp_d[mon_k - 3];
      end
      chk("x_out", 32'(bus_if.x_out), 32'(last_x));
      chk("d_out", 32'(bus_if.d_out), 32'(last_d));
    end
  end

  task automatic launch(input int len, input logic [15:0] a,
                        input logic [15:0] h0v, input logic [15:0] h1v);
    build_model(len, a, h0v, h1v);
    @(posedge clk); #1;
    bus_if.start     = 1'b1;
    bus_if.train_len = CW'(len);
    bus_if.amp       = a;
    bus_if.h0        = h0v;
    bus_if.h1        = h1v;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    // Disturb the live config; the run must keep its latched copy.
    bus_if.amp       = 16'(($urandom & 32'h7FFF) | 32'h1);
    bus_if.h0        = 16'($urandom);
    bus_if.h1        = 16'($urandom);
    bus_if.train_len = 16'($urandom);
    mon_l  = len;
    mon_k  = 0;
    vcount = 0;
    mon_en = 1;
  endtask

  task automatic run(input int len, input logic [15:0] a,
                     input logic [15:0] h0v, input logic [15:0] h1v, input bit poke);
    launch(len, a, h0v, h1v);
    repeat (len + 5) begin
      @(posedge clk); #1;
      bus_if.start = (poke && mon_k == 2) ? 1'b1 : 1'b0;
    end
    bus_if.start = 1'b0;
    mon_en = 0;
    chk("valid_count", 32'(vcount), 32'(len));
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.train_len = '0;
    bus_if.amp       = '0;
    bus_if.h0        = '0;
    bus_if.h1        = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_x",     32'(bus_if.x_out), 32'h0);
    chk("rst_d",     32'(bus_if.d_out), 32'h0);
    chk("rst_valid", 32'(bus_if.valid), 32'h0);
    chk("rst_busy",  32'(bus_if.busy),  32'h0);
    chk("rst_done",  32'(bus_if.done),  32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(bus_if.busy), 32'h0);

    // Plain h0 tap.
    build_model(3, 16'h1000, 16'h4000, 16'h0000);
    chk("model_x0", 32'(exp_x[0]), 32'hF000);
    chk("model_x1", 32'(exp_x[1]), 32'h1000);
    chk("model_d0", 32'(exp_d[0]), 32'hF800);
    chk("model_d1", 32'(exp_d[1]), 32'h0800);
    run(3, 16'h1000, 16'h4000, 16'h0000, 1'b0);

    // Delayed tap only: first sample sees prev = 0.
    build_model(2, 16'h1000, 16'h0000, 16'h4000);
    chk("model_h1_d0", 32'(exp_d[0]), 32'h0000);
    chk("model_h1_d1", 32'(exp_d[1]), 32'hF800);
    run(2, 16'h1000, 16'h0000, 16'h4000, 1'b0);

    // Saturation corner.
    build_model(3, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    chk("model_sat_d0", 32'(exp_d[0]), 32'h8001);
    chk("model_sat_d1", 32'(exp_d[1]), 32'h0000);
    chk("model_sat_d2", 32'(exp_d[2]), 32'h7FFF);
    run(3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);

    // Zero-length run.
    run(0, 16'h1000, 16'h4000, 16'h0000, 1'b0);

    // Start during busy is ignored.
    run(5, 16'h0800, 16'h2000, 16'hE000, 1'b1);

    // Reset mid-run.
    launch(10, 16'h1000, 16'h4000, 16'h2000);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_x",     32'(bus_if.x_out), 32'h0);
    chk("mid_rst_d",     32'(bus_if.d_out), 32'h0);
    chk("mid_rst_valid", 32'(bus_if.valid), 32'h0);
    chk("mid_rst_busy",  32'(bus_if.busy),  32'h0);
    chk("mid_rst_done",  32'(bus_if.done),  32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    last_x = 16'h0;
    last_d = 16'h0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_busy",  32'(bus_if.busy),  32'h0);
      chk("post_rst_done",  32'(bus_if.done),  32'h0);
      chk("post_rst_valid", 32'(bus_if.valid), 32'h0);
    end
    build_model(10, 16'h1000, 16'h4000, 16'h2000);
    chk("restart_model_x0", 32'(exp_x[0]), 32'hF000);
    chk("restart_model_d0", 32'(exp_d[0]), 32'hF800);
    run(10, 16'h1000, 16'h4000, 16'h2000, 1'b0);

    // Long random run.
    begin
      logic [15:0] ra;
      logic [15:0] rh0;
      logic [15:0] rh1;
      ra  = 16'($urandom_range(1, 32767));
      rh0 = 16'($urandom);
      rh1 = 16'($urandom);
      run(1000, ra, rh0, rh1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
